// File: rtl/mod_updown_counter.sv
// Parametrised modulo-MOD_VAL up/down counter with clear, load, wrap/saturate and tc/ovf flags.
// Optional registered Gray-coded output q_gray when GRAY_OUT_EN is defined.
module mod_updown_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MOD_VAL  = 16,
  parameter int unsigned      SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
`ifdef GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  // Modulus held in WIDTH+1 bits so MOD_VAL == 2^WIDTH compares without truncation.
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MOD_VAL);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MOD_VAL - 64'd1);

  initial begin
    if (WIDTH < 2 || WIDTH > 32) begin
      $error("mod_updown_counter: WIDTH must be in 2..32");
    end
    if (MOD_VAL < 2 || MOD_VAL > (64'd1 << WIDTH)) begin
      $error("mod_updown_counter: MOD_VAL must be in 2..2^WIDTH");
    end
`ifdef GRAY_OUT_EN
    if (MOD_VAL != (64'd1 << WIDTH)) begin
      $error("mod_updown_counter: GRAY_OUT_EN requires MOD_VAL == 2^WIDTH");
    end
`endif
  end

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next_q;
  logic             w_next_ovf;
  logic [WIDTH-1:0] w_load_q;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == LP_MAX);
  assign w_at_zero = (r_q == '0);
  assign w_load_q  = ({1'b0, load_val} >= LP_MOD) ? LP_MAX : load_val;

  always_comb begin
    w_next_q   = r_q;
    w_next_ovf = 1'b0;
    if (clear) begin
      w_next_q = '0;
    end else if (load) begin
      w_next_q = w_load_q;
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max) begin
          w_next_ovf = 1'b1;
          w_next_q   = (SATURATE != 0) ? r_q : '0;
        end else begin
          w_next_q = r_q + 1'b1;
        end
      end else begin
        if (w_at_zero) begin
          w_next_ovf = 1'b1;
          w_next_q   = (SATURATE != 0) ? r_q : LP_MAX;
        end else begin
          w_next_q = r_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_next_q;
      r_ovf <= w_next_ovf;
    end
  end

`ifdef GRAY_OUT_EN
  logic [WIDTH-1:0] r_q_gray;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_gray <= '0;
    end else begin
      r_q_gray <= w_next_q ^ (w_next_q >> 1);
    end
  end

  assign q_gray = r_q_gray;
`endif

  assign q   = r_q;
  assign ovf = r_ovf;
  assign tc  = (up_dn & w_at_max) | (~up_dn & w_at_zero);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: default wrap counter plus MOD_VAL=10 wrap and saturate
// instances sharing one stimulus stream.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;

  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
  logic       ovf0, ovf1, ovf2;
`ifdef GRAY_OUT_EN
  logic [3:0] g0, g1, g2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_updown_counter u_dut0 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .q(q0), .tc(tc0), .ovf(ovf0)
`ifdef GRAY_OUT_EN
    , .q_gray(g0)
`endif
  );

  mod_updown_counter #(.WIDTH(4), .MOD_VAL(10), .SATURATE(0)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .q(q1), .tc(tc1), .ovf(ovf1)
`ifdef GRAY_OUT_EN
    , .q_gray(g1)
`endif
  );

  mod_updown_counter #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1)) u_dut2 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .q(q2), .tc(tc2), .ovf(ovf2)
`ifdef GRAY_OUT_EN
    , .q_gray(g2)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_q3   [5];
    logic       exp_ovf3 [5];
    logic [3:0] eq;
    exp_q3   = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    exp_ovf3 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset state
    #1 reset = 1'b1;
    #1;
    check_eq("rst_q", q0, 0);
    check_eq("rst_ovf", ovf0, 0);
    step();
    reset = 1'b0;

    // Count to 5, then reset asynchronously mid-cycle
    en = 1'b1; up_dn = 1'b1;
    repeat (5) step();
    check_eq("pre_rst_q", q0, 5);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_q", q0, 0);
    check_eq("async_rst_ovf", ovf0, 0);
    check_eq("async_rst_tc", tc0, 0);
    step();
    step();
    check_eq("held_in_rst_q", q0, 0);
    reset = 1'b0;

    // 20 up counts through the 15 -> 0 wrap
    for (int i = 1; i <= 20; i++) begin
      step();
      eq = 4'(i % 16);
      check_eq($sformatf("up_q_%0d", i), q0, eq);
      check_eq($sformatf("up_ovf_%0d", i), ovf0, (i == 16) ? 1 : 0);
      check_eq($sformatf("up_tc_%0d", i), tc0, (eq == 4'd15) ? 1 : 0);
`ifdef GRAY_OUT_EN
      check_eq($sformatf("gray_%0d", i), g0, eq ^ (eq >> 1));
`endif
    end

    // MOD_VAL=10 wrap, counting down from 0
    en = 1'b0; up_dn = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clr_q1", q1, 0);
    check_eq("clr_ovf1", ovf1, 0);
    check_eq("dn_tc1_at0", tc1, 1);
    en = 1'b1;
    step();
    check_eq("dn_wrap_q1", q1, 9);
    check_eq("dn_wrap_ovf1", ovf1, 1);
    check_eq("dn_wrap_tc1", tc1, 0);
    step();
    check_eq("dn_q1_8", q1, 8);
    check_eq("dn_ovf1_8", ovf1, 0);
    step();
    check_eq("dn_q1_7", q1, 7);

    // MOD_VAL=10 saturate, counting up from 7
    en = 1'b0; load = 1'b1; load_val = 4'd7;
    step();
    load = 1'b0;
    check_eq("ld7_q2", q2, 7);
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("sat_q2_%0d", i), q2, exp_q3[i]);
      check_eq($sformatf("sat_ovf2_%0d", i), ovf2, exp_ovf3[i]);
    end
    check_eq("wrap_q1_after", q1, 2);
    en = 1'b0;
    step();
    check_eq("sat_hold_q2", q2, 9);
    check_eq("sat_hold_ovf2", ovf2, 0);

    // Clamped load, clear over load, load over en
    load = 1'b1; load_val = 4'd12; en = 1'b1; up_dn = 1'b1;
    step();
    check_eq("clamp_q1", q1, 9);
    check_eq("clamp_ovf1", ovf1, 0);
    check_eq("noclamp_q0", q0, 12);
    clear = 1'b1;
    step();
    check_eq("clr_over_ld_q1", q1, 0);
    clear = 1'b0; load_val = 4'd4;
    step();
    check_eq("ld_over_en_q1", q1, 4);
    check_eq("ld_over_en_ovf1", ovf1, 0);

    // Enable gating with a direction flip at q=3
    load_val = 4'd3; en = 1'b0;
    step();
    load = 1'b0;
    check_eq("ld3_q1", q1, 3);
    up_dn = 1'b0;
    step();
    check_eq("en0_q1", q1, 3);
    en = 1'b1;
    step();
    check_eq("dn_q1_2", q1, 2);
    up_dn = 1'b1;
    step();
    check_eq("up_q1_3", q1, 3);
    en = 1'b0;

    // tc follows up_dn combinationally at both ends
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0; up_dn = 1'b1;
    #1 check_eq("tc1_q0_up", tc1, 0);
    up_dn = 1'b0;
    #1 check_eq("tc1_q0_dn", tc1, 1);
    load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0; up_dn = 1'b1;
    #1 check_eq("tc1_q9_up", tc1, 1);
    up_dn = 1'b0;
    #1 check_eq("tc1_q9_dn", tc1, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
